// File: rtl/sram_like_responder.sv
// sram_like_responder: responder end of the SRAM-like request interface.
// Requests are served from an internal word-addressed memory at acceptance;
// responses are queued and released in order a fixed LATENCY edges later.
// A request accepted at clock edge k has data_ok asserted by edge k+LATENCY.
module sram_like_responder #(
  parameter int ADDR_WIDTH      = 10,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        busy
);

  // Slot index width; a depth-1 queue still gets a 1-bit index so the
  // pointer arithmetic below stays uniform.
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int PW = IW + 1;
  localparam int QD = 2 ** IW;
  localparam logic [PW-1:0] MAX_CNT  = PW'(MAX_OUTSTANDING);
  localparam logic [3:0]    CNT_INIT = 4'(LATENCY - 1);

  typedef struct packed {
    logic        valid;
    logic        is_read;
    logic [31:0] data;
    logic [3:0]  cnt;
  } entry_t;

  logic [31:0]           mem [2**ADDR_WIDTH];
  entry_t                q   [QD];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count;
  logic [PW-1:0]         count_next;
  logic [IW-1:0]         head;
  logic [IW-1:0]         tail;
  logic                  pop;
  logic                  accept;
  logic                  misaligned;
  logic [3:0]            be;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           rd_word;
  logic                  unused_addr_bits;

  // Pointers carry one extra bit so a full queue differs from an empty one.
  assign head       = rd_ptr[IW-1:0];
  assign tail       = wr_ptr[IW-1:0];
  assign count      = wr_ptr - rd_ptr;
  assign pop        = q[head].valid && (q[head].cnt == 4'd0);
  // A full queue can still accept when its head leaves in the same cycle.
  assign addr_ok    = req && !stall && ((count < MAX_CNT) || pop);
  assign accept     = req && addr_ok;
  assign count_next = count + PW'(accept) - PW'(pop);

  // Upper address bits are ignored, so the memory aliases across them.
  assign word_idx         = addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];
  assign rd_word          = mem[word_idx];

  // Decode size/offset into byte-lane enables and the misalignment flag.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    misaligned = 1'b0;
    be         = 4'b1111;
    case (size)
      2'd0: be = 4'b0001 << addr[1:0];
      2'd1: begin
        be         = 4'b0011 << addr[1:0];
        misaligned = addr[0];
      end
      default: misaligned = (addr[1:0] != 2'b00);
    endcase
    // Misaligned writes are answered normally but must not touch memory.
    if (misaligned) be = 4'b0000;
  end

  // Commit enabled write lanes at the edge that ends the accept cycle.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; contents survive rst and it maps onto plain RAM.
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Response queue: push on accept, count down every entry, pop the due head.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < QD; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < QD; i++) begin
        if (q[i].valid && (q[i].cnt != 4'd0)) q[i].cnt <= q[i].cnt - 4'd1;
      end
      if (pop) begin
        q[head].valid <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      // When full, tail and head share a slot; the push below wins the write.
      if (accept) begin
        q[tail] <= '{valid: 1'b1, is_read: !wr, data: rd_word, cnt: CNT_INIT};
        wr_ptr  <= wr_ptr + PW'(1);
      end
    end
  end

  // Registered response, misalignment pulse and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_ok  <= 1'b0;
      rdata    <= '0;
      misalign <= 1'b0;
      busy     <= 1'b0;
    end else begin
      data_ok  <= pop;
      rdata    <= (pop && q[head].is_read) ? q[head].data : '0;
      misalign <= accept && misaligned;
      // busy covers the data_ok cycle of the last outstanding response.
      busy     <= (count_next != '0) || pop;
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Testbench for sram_like_responder: two instances (LATENCY=1/MAX_OUTSTANDING=4
// and LATENCY=3/MAX_OUTSTANDING=2), a vector table, hand-written multi-cycle
// sequences, and randomized traffic against a due-time scoreboard model.
// Timing: inputs change 1ns after a rising edge; outputs are sampled on the
// falling edge. A request accepted in loop iteration i shows data_ok in
// iteration i+LATENCY+1.
module tb_sram_like_responder;

  localparam int LAT0 = 1;
  localparam int MO0  = 4;
  localparam int LAT1 = 3;
  localparam int MO1  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req      [2];
  logic        wr       [2];
  logic [1:0]  size     [2];
  logic [31:0] addr     [2];
  logic [31:0] wdata    [2];
  logic        stall    [2];
  logic        addr_ok  [2];
  logic        data_ok  [2];
  logic [31:0] rdata    [2];
  logic        misalign [2];
  logic        busy     [2];

  int n_vec = 0;
  int n_err = 0;

  sram_like_responder #(.ADDR_WIDTH(10), .LATENCY(LAT0), .MAX_OUTSTANDING(MO0)) dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .size(size[0]), .addr(addr[0]),
    .wdata(wdata[0]), .stall(stall[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]),
    .rdata(rdata[0]), .misalign(misalign[0]), .busy(busy[0]));

  sram_like_responder #(.ADDR_WIDTH(10), .LATENCY(LAT1), .MAX_OUTSTANDING(MO1)) dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .size(size[1]), .addr(addr[1]),
    .wdata(wdata[1]), .stall(stall[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]),
    .rdata(rdata[1]), .misalign(misalign[1]), .busy(busy[1]));

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_mis;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          known;
  } resp_t;

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int mo_of(input int d);
    return (d == 0) ? MO0 : MO1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted request on an idle instance; reports latency, data, misalign pulses.
  task automatic do_req(input int d, input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got_rd, output int got_lat,
                        output int n_mis);
    req[d] = 1'b1; wr[d] = w; size[d] = sz; addr[d] = a; wdata[d] = wd; stall[d] = 1'b0;
    @(negedge clk);
    check($sformatf("do_req d%0d addr_ok @%h", d, a), 32'(addr_ok[d]), 32'd1);
    n_mis = misalign[d] ? 1 : 0;
    tick();
    req[d]  = 1'b0;
    got_lat = -1;
    got_rd  = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (misalign[d]) n_mis++;
      if (data_ok[d] && got_lat < 0) begin
        got_lat = n;
        got_rd  = rdata[d];
      end
      tick();
    end
  endtask

  // Randomized traffic checked against a queue of responses keyed by due cycle
  // and a byte-granular memory image.
  task automatic random_run(input int d, input int ncyc);
    resp_t       rq[$];
    logic [7:0]  mm[int];
    bit          e_dok = 1'b0, e_known = 1'b1, e_mis = 1'b0, e_busy = 1'b0;
    logic [31:0] e_rd = '0;
    bit          pend = 1'b0, r_wr = 1'b0, st, pop_now, exp_ok, mis, known;
    logic [1:0]  r_sz = 2'd0;
    logic [31:0] r_a = '0, r_wd = '0, data;
    int          nb, wi, key;
    for (int c = 0; c < ncyc + 40; c++) begin
      if (!pend && c < ncyc && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        r_wr = 1'($urandom_range(0, 1));
        r_sz = 2'($urandom_range(0, 3));
        r_a  = ($urandom & 32'hFFFF_F000) | (32'h800 + 32'($urandom_range(0, 127)));
        r_wd = $urandom;
      end
      st = (c < ncyc) && ($urandom_range(0, 3) == 0);
      req[d] = pend; wr[d] = r_wr; size[d] = r_sz; addr[d] = r_a; wdata[d] = r_wd; stall[d] = st;
      @(negedge clk);
      pop_now = (rq.size() > 0) && (rq[0].due == c);
      exp_ok  = pend && !st && ((rq.size() < mo_of(d)) || pop_now);
      check($sformatf("rnd d%0d c%0d addr_ok", d, c), 32'(addr_ok[d]), 32'(exp_ok));
      check($sformatf("rnd d%0d c%0d data_ok", d, c), 32'(data_ok[d]), 32'(e_dok));
      if (e_known) check($sformatf("rnd d%0d c%0d rdata", d, c), rdata[d], e_rd);
      check($sformatf("rnd d%0d c%0d misalign", d, c), 32'(misalign[d]), 32'(e_mis));
      check($sformatf("rnd d%0d c%0d busy", d, c), 32'(busy[d]), 32'(e_busy));
      // Advance the model by one clock edge.
      e_dok = pop_now; e_rd = '0; e_known = 1'b1;
      if (pop_now) begin
        e_rd    = rq[0].data;
        e_known = rq[0].known;
        void'(rq.pop_front());
      end
      nb    = 1 << ((r_sz > 2'd2) ? 2 : int'(r_sz));
      mis   = (r_a % nb) != 0;
      wi    = int'((r_a >> 2) % 1024);
      e_mis = exp_ok && mis;
      if (exp_ok) begin
        known = 1'b1;
        data  = '0;
        for (int k = 0; k < 4; k++) begin
          key = d * 65536 + wi * 4 + k;
          if (mm.exists(key)) data[8*k +: 8] = mm[key];
          else known = 1'b0;
        end
        rq.push_back('{due: c + lat_of(d), data: r_wr ? 32'd0 : data, known: r_wr ? 1'b1 : known});
        if (r_wr && !mis) begin
          for (int k = int'(r_a % 4); k < int'(r_a % 4) + nb; k++) mm[d * 65536 + wi * 4 + k] = r_wd[8*k +: 8];
        end
      end
      e_busy = (rq.size() != 0) || pop_now;
      if (addr_ok[d]) pend = 1'b0;
      tick();
    end
    req[d] = 1'b0; stall[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[14];
    logic [31:0] w1[4];
    logic [31:0] bb_addr[4];
    logic [31:0] bb_exp[4];
    logic [31:0] got_rd;
    logic [31:0] dok_rd[4];
    int          got_lat, n_mis, na, nd;
    int          acc_at[4];
    int          dok_at[4];
    bit          aok[16];
    bit          bsy[16];
    bit          exp_pat[5];

    vecs[0]  = '{1'b1, 2'd2, 32'h100,  32'hDEADBEEF, 32'h0,        0};
    vecs[1]  = '{1'b0, 2'd2, 32'h100,  32'h0,        32'hDEADBEEF, 0};
    vecs[2]  = '{1'b1, 2'd2, 32'h40,   32'h0,        32'h0,        0};
    vecs[3]  = '{1'b1, 2'd0, 32'h41,   32'h0000AB00, 32'h0,        0};
    vecs[4]  = '{1'b1, 2'd1, 32'h42,   32'hCDEF0000, 32'h0,        0};
    vecs[5]  = '{1'b0, 2'd2, 32'h40,   32'h0,        32'hCDEFAB00, 0};
    vecs[6]  = '{1'b1, 2'd2, 32'h200,  32'h11223344, 32'h0,        0};
    vecs[7]  = '{1'b1, 2'd1, 32'h201,  32'hFFFFFFFF, 32'h0,        1};
    vecs[8]  = '{1'b0, 2'd2, 32'h200,  32'h0,        32'h11223344, 0};
    vecs[9]  = '{1'b0, 2'd2, 32'h202,  32'h0,        32'h11223344, 1};
    vecs[10] = '{1'b1, 2'd3, 32'h300,  32'hA5A55A5A, 32'h0,        0};
    vecs[11] = '{1'b0, 2'd3, 32'h300,  32'h0,        32'hA5A55A5A, 0};
    vecs[12] = '{1'b0, 2'd2, 32'h1100, 32'h0,        32'hDEADBEEF, 0};
    vecs[13] = '{1'b0, 2'd0, 32'h103,  32'h0,        32'hDEADBEEF, 0};

    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; size[d] = 2'd0; addr[d] = '0; wdata[d] = '0; stall[d] = 1'b0;
    end

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset d%0d data_ok", d), 32'(data_ok[d]), 32'd0);
      check($sformatf("reset d%0d rdata", d), rdata[d], 32'd0);
      check($sformatf("reset d%0d misalign", d), 32'(misalign[d]), 32'd0);
      check($sformatf("reset d%0d busy", d), 32'(busy[d]), 32'd0);
      check($sformatf("reset d%0d addr_ok", d), 32'(addr_ok[d]), 32'd0);
    end
    tick();
    rst = 1'b0;
    tick();

    // Vector table on the LATENCY=1 instance.
    for (int i = 0; i < 14; i++) begin
      do_req(0, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, got_rd, got_lat, n_mis);
      check($sformatf("vec%0d latency", i), 32'(got_lat), 32'(LAT0 + 1));
      check($sformatf("vec%0d rdata", i), got_rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d misalign pulses", i), 32'(n_mis), 32'(vecs[i].exp_mis));
    end

    // Back-to-back reads, LATENCY=1: one accept and one response per cycle.
    bb_addr[0] = 32'h100; bb_addr[1] = 32'h40; bb_addr[2] = 32'h200; bb_addr[3] = 32'h300;
    bb_exp[0] = 32'hDEADBEEF; bb_exp[1] = 32'hCDEFAB00; bb_exp[2] = 32'h11223344; bb_exp[3] = 32'hA5A55A5A;
    na = 0; nd = 0;
    for (int i = 0; i < 10; i++) begin
      req[0] = (na < 4); wr[0] = 1'b0; size[0] = 2'd2; addr[0] = bb_addr[(na < 4) ? na : 3];
      @(negedge clk);
      if (data_ok[0]) begin
        if (nd < 4) begin dok_at[nd] = i; dok_rd[nd] = rdata[0]; end
        nd++;
      end
      if (addr_ok[0] && na < 4) begin acc_at[na] = i; na++; end
      tick();
    end
    req[0] = 1'b0;
    check("b2b response count", 32'(nd), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b accept%0d cycle", k), 32'(acc_at[k]), 32'(k));
      check($sformatf("b2b resp%0d cycle", k), 32'(dok_at[k]), 32'(k + LAT0 + 1));
      check($sformatf("b2b resp%0d rdata", k), dok_rd[k], bb_exp[k]);
    end

    // Preload the LATENCY=3 instance.
    for (int k = 0; k < 4; k++) begin
      w1[k] = 32'h1000_0000 + 32'(k) * 32'h0101_0111;
      do_req(1, 1'b1, 2'd2, 32'h10 + 32'(4 * k), w1[k], got_rd, got_lat, n_mis);
      check($sformatf("preload%0d latency", k), 32'(got_lat), 32'(LAT1 + 1));
      check($sformatf("preload%0d rdata", k), got_rd, 32'd0);
    end

    // LATENCY=3, MAX_OUTSTANDING=2: req held for four reads.
    exp_pat[0] = 1'b1; exp_pat[1] = 1'b1; exp_pat[2] = 1'b0; exp_pat[3] = 1'b1; exp_pat[4] = 1'b1;
    na = 0; nd = 0;
    for (int i = 0; i < 12; i++) begin
      req[1] = (na < 4); wr[1] = 1'b0; size[1] = 2'd2; addr[1] = 32'h10 + 32'(4 * ((na < 4) ? na : 3));
      @(negedge clk);
      aok[i] = addr_ok[1];
      bsy[i] = busy[1];
      if (data_ok[1]) begin
        if (nd < 4) begin dok_at[nd] = i; dok_rd[nd] = rdata[1]; end
        nd++;
      end
      if (addr_ok[1] && na < 4) begin acc_at[na] = i; na++; end
      tick();
    end
    req[1] = 1'b0;
    for (int i = 0; i < 5; i++) check($sformatf("full addr_ok cycle%0d", i), 32'(aok[i]), 32'(exp_pat[i]));
    check("full response count", 32'(nd), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("full resp%0d delay", k), 32'(dok_at[k] - acc_at[k]), 32'(LAT1 + 1));
      check($sformatf("full resp%0d rdata", k), dok_rd[k], w1[k]);
    end
    check("full busy on last data_ok", 32'(bsy[8]), 32'd1);
    check("full busy after last data_ok", 32'(bsy[9]), 32'd0);

    // Stall: one read in flight drains on schedule while a second request waits.
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      req[1] = (i <= 6); wr[1] = 1'b0; size[1] = 2'd2;
      addr[1] = (i == 0) ? 32'h14 : 32'h10;
      stall[1] = (i >= 1 && i <= 5);
      @(negedge clk);
      aok[i] = addr_ok[1];
      if (data_ok[1]) begin
        if (nd < 4) begin dok_at[nd] = i; dok_rd[nd] = rdata[1]; end
        nd++;
      end
      tick();
    end
    req[1] = 1'b0; stall[1] = 1'b0;
    check("stall addr_ok first", 32'(aok[0]), 32'd1);
    for (int i = 1; i <= 5; i++) check($sformatf("stall addr_ok cycle%0d", i), 32'(aok[i]), 32'd0);
    check("stall addr_ok released", 32'(aok[6]), 32'd1);
    check("stall response count", 32'(nd), 32'd2);
    check("stall drain cycle", 32'(dok_at[0]), 32'(LAT1 + 1));
    check("stall drain rdata", dok_rd[0], w1[1]);
    check("stall release resp cycle", 32'(dok_at[1]), 32'(6 + LAT1 + 1));
    check("stall release rdata", dok_rd[1], w1[0]);

    // rst with two reads outstanding: both responses are dropped.
    nd = 0; na = 0;
    for (int i = 0; i < 11; i++) begin
      req[1] = (i <= 1); wr[1] = 1'b0; size[1] = 2'd2; addr[1] = (i == 0) ? 32'h10 : 32'h14;
      rst = (i == 2);
      @(negedge clk);
      if (addr_ok[1] && i <= 1) na++;
      if (data_ok[1]) nd++;
      if (i == 3) check("rst busy cleared", 32'(busy[1]), 32'd0);
      tick();
    end
    req[1] = 1'b0; rst = 1'b0;
    check("rst reads accepted", 32'(na), 32'd2);
    check("rst dropped responses", 32'(nd), 32'd0);
    do_req(1, 1'b1, 2'd2, 32'h20, 32'h5555AAAA, got_rd, got_lat, n_mis);
    check("post-rst write latency", 32'(got_lat), 32'(LAT1 + 1));
    do_req(1, 1'b0, 2'd2, 32'h18, 32'h0, got_rd, got_lat, n_mis);
    check("post-rst read latency", 32'(got_lat), 32'(LAT1 + 1));
    check("post-rst read keeps memory", got_rd, w1[2]);

    // Randomized traffic against the reference model on both instances.
    random_run(0, 400);
    random_run(1, 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
